// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, op encoding, mstatus/mie/mip bit positions, cause codes and the Zicsr write-combine helper
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;
  typedef enum logic [1:0] {CSR_NONE = 2'b00, CSR_RW = 2'b01, CSR_RS = 2'b10, CSR_RC = 2'b11} csr_op_e;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;
  localparam logic [31:0] MSTATUS_MASK = (32'd1 << MSTATUS_MIE) | (32'd1 << MSTATUS_MPIE);
  localparam logic [31:0] MIE_MASK     = (32'd1 << MIE_MTIE) | (32'd1 << MIE_MEIE);
  localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;
  localparam logic [31:0] CAUSE_MTI    = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI    = 32'h8000_000B;
  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_v, input logic [31:0] wdata);
    return op == CSR_RW ? wdata : op == CSR_RS ? (old_v | wdata) : op == CSR_RC ? (old_v & ~wdata) : old_v;
  endfunction
endpackage

// File: rtl/csr_regfile_cycle_counter64.sv
// cycle_counter64: free-running 64-bit counter; ports clk/rst, lo/hi write enables+data, count_o; a low write suppresses the increment and its carry, a high write drops the low-half carry
module cycle_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        lo_we_i,
  input  logic        hi_we_i,
  input  logic [31:0] lo_wdata_i,
  input  logic [31:0] hi_wdata_i,
  output logic [63:0] count_o
);
  logic [31:0] lo_q, lo_d, hi_q, hi_d;
  logic [32:0] lo_inc;
  assign lo_inc = {1'b0, lo_q} + 33'd1;
  always_comb begin
    lo_d = lo_we_i ? lo_wdata_i : lo_inc[31:0];
    hi_d = hi_we_i ? hi_wdata_i : hi_q + {31'd0, lo_inc[32] & ~lo_we_i};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end
  assign count_o = {hi_q, lo_q};
endmodule

// File: rtl/csr_regfile.sv
// csr_regfile: M-mode CSR file; in: clk, rst, pc, csr_addr/wdata/op, is_mret, timer_intr, ext_intr; out: csr_rdata (old value), epc_taken/epc (trap or mret redirect)
module csr_regfile
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic [1:0]  csr_op,
  input  logic        is_mret,
  input  logic        timer_intr,
  input  logic        ext_intr,
  output logic [31:0] csr_rdata,
  output logic        epc_taken,
  output logic [31:0] epc
);
  logic [31:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mip_q, mip_d;
  logic [63:0] cycle;
  logic [31:0] wval;
  logic        intr_pend, ext_pend, trap, wr_en;
  csr_op_e     op;
  assign op        = csr_op_e'(csr_op);
  assign intr_pend = mstatus_q[MSTATUS_MIE] & |(mie_q & mip_q);
  assign ext_pend  = mie_q[MIE_MEIE] & mip_q[MIP_MEIP];
  assign trap      = intr_pend & ~is_mret;
  assign epc_taken = ~rst & (trap | is_mret);
  assign epc       = (~rst & is_mret) ? mepc_q : mtvec_q;
  // the trapped instruction is flushed, so its CSR write must not land
  assign wr_en     = (op != CSR_NONE) & ~trap;
  assign wval      = csr_apply(op, csr_rdata, csr_wdata);
  always_comb begin
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = mstatus_q;
      CSR_MIE:     csr_rdata = mie_q;
      CSR_MTVEC:   csr_rdata = mtvec_q;
      CSR_MEPC:    csr_rdata = mepc_q;
      CSR_MCAUSE:  csr_rdata = mcause_q;
      CSR_MIP:     csr_rdata = mip_q;
      CSR_MCYCLE:  csr_rdata = cycle[31:0];
      CSR_MCYCLEH: csr_rdata = cycle[63:32];
      default:     csr_rdata = '0;
    endcase
  end
  always_comb begin
    mstatus_d = (wr_en && csr_addr == CSR_MSTATUS) ? (wval & MSTATUS_MASK) : mstatus_q;
    if (trap) begin
      mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
      mstatus_d[MSTATUS_MIE]  = 1'b0;
    end else if (is_mret) begin
      mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
      mstatus_d[MSTATUS_MPIE] = 1'b1;
    end
    mie_d    = (wr_en && csr_addr == CSR_MIE) ? (wval & MIE_MASK) : mie_q;
    mtvec_d  = (wr_en && csr_addr == CSR_MTVEC) ? (wval & ALIGN_MASK) : mtvec_q;
    mepc_d   = trap ? (pc & ALIGN_MASK) : (wr_en && csr_addr == CSR_MEPC) ? (wval & ALIGN_MASK) : mepc_q;
    mcause_d = trap ? (ext_pend ? CAUSE_MEI : CAUSE_MTI) : (wr_en && csr_addr == CSR_MCAUSE) ? wval : mcause_q;
    mip_d            = '0;
    mip_d[MIP_MTIP]  = timer_intr;
    mip_d[MIP_MEIP]  = ext_intr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q <= '0;
      mie_q     <= '0;
      mtvec_q   <= MTVEC_RESET;
      mepc_q    <= '0;
      mcause_q  <= '0;
      mip_q     <= '0;
    end else begin
      mstatus_q <= mstatus_d;
      mie_q     <= mie_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
      mip_q     <= mip_d;
    end
  end
  cycle_counter64 u_cycle (
    .clk        (clk),
    .rst        (rst),
    .lo_we_i    (wr_en && csr_addr == CSR_MCYCLE),
    .hi_we_i    (wr_en && csr_addr == CSR_MCYCLEH),
    .lo_wdata_i (wval),
    .hi_wdata_i (wval),
    .count_o    (cycle)
  );
endmodule

// File: doc/csr_regfile.md
# csr_regfile

Machine-mode control/status register file for the three-stage RISC-V core. It sits in the execute/writeback stage beside the ALU and data memory, and its `rdata` feeds the `2'b11` (CSR) leg of the writeback select mux. It implements Zicsr reads and writes, a 64-bit cycle counter, timer and external interrupt entry, and `mret`. It produces the PC redirect the fetch stage uses on a trap or a return.

## Interface
Parameters:
- `MTVEC_RESET`, default `32'h0000_0000`: reset value of `mtvec`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`, input, 1: clock.
  - `rst`, input, 1: reset.
- Instruction inputs:
  - `pc`, input, 32: PC of the instruction currently in this stage.
  - `csr_addr`, input, 12: CSR address (`instr[31:20]`).
  - `csr_wdata`, input, 32: rs1 value, or zero-extended uimm.
  - `csr_op`, input, 2: `00` none, `01` RW, `10` RS, `11` RC.
  - `is_mret`, input, 1: the current instruction is `mret`.
- Interrupt lines:
  - `timer_intr`, input, 1: level-sensitive timer interrupt line.
  - `ext_intr`, input, 1: level-sensitive external interrupt line.
- Outputs:
  - `csr_rdata`, output, 32: old value of the addressed CSR (combinational).
  - `epc_taken`, output, 1: redirect fetch this cycle and flush the current instruction.
  - `epc`, output, 32: redirect target.

## Operation
Implemented CSRs (any other address reads 0, and writes to it are ignored):
- `mstatus` (0x300): only MIE[3] and MPIE[7] are writable. All other bits read 0.
- `mie` (0x304): only MTIE[7] and MEIE[11] are writable.
- `mtvec` (0x305): direct mode only. Bits [1:0] are forced to 0 on write.
- `mepc` (0x341): bits [1:0] are forced to 0.
- `mcause` (0x342): fully writable.
- `mip` (0x344): read-only. MTIP[7] and MEIP[11] are registered copies of `timer_intr` and `ext_intr`, sampled every cycle.
- `mcycle` (0xB00) and `mcycleh` (0xB80): low and high halves of a 64-bit counter.

Write rules:
- The write value is RW: `wdata`; RS: `old | wdata`; RC: `old & ~wdata`.
- The result is then masked to the writable bits.
- A write commits at the clock edge. `csr_rdata` always returns the pre-write value.

Interrupt entry:
- `intr_pend = mstatus.MIE & |(mie & mip)`.
- External has priority over timer.
- When `intr_pend` is set and `is_mret` is low:
  - `epc_taken` = 1 and `epc` = `mtvec`.
  - At the edge: `mepc <= pc`, `mcause <= 32'h8000_000B` (external) or `32'h8000_0007` (timer), `MPIE <= MIE`, `MIE <= 0`.
  - Any CSR write in that cycle is suppressed, because the instruction is flushed.

`mret`:
- `epc_taken` = 1 and `epc` = `mepc`.
- At the edge: `MIE <= MPIE`, `MPIE <= 1`.
- An interrupt pending in the same cycle is deferred. It is taken the next cycle if the restored MIE permits.

Cycle counter:
- Increments by 1 every cycle and wraps from `2^64-1` to 0.
- A write to `mcycle` replaces the low 32 bits and inhibits the increment, and its carry, for that cycle.
- A write to `mcycleh` replaces the high 32 bits, while the low half increments normally. A carry out of the low half in that cycle is discarded.

## Timing
Reset values:
- `mstatus`, `mie`, `mepc`, `mcause`, `mip`, `mcycle`: 0.
- `mtvec` = `MTVEC_RESET`.
- `epc_taken` = 0 and `epc` = `mtvec` during reset, since it is combinational from registered state.

Reset while a trap or `mret` is in flight: reset wins and all state returns to its reset value.

Latency:
- `csr_rdata`: 0 cycles, combinational from `csr_addr` and registered state.
- Interrupt: a line that rises before edge N is visible in `mip` after edge N. `epc_taken` rises in cycle N+1 if the interrupt is enabled.
- `mcycle` read in cycle k equals k, counting the number of edges since reset was released.

## Structure
- Package `csr_pkg` holds:
  - CSR address localparams.
  - The `csr_op_e` enum.
  - The mstatus/mie/mip bit-position constants.
  - The cause codes.
- Sub-module `cycle_counter64` is the 64-bit counter with separate low and high write ports and the carry-inhibit rule.

## Test plan
- **Read/write ops:** reset, RW 0x305 with `0x8000_0103`, then read → `0x8000_0100`. RS 0x304 with `0x880` → 0x880. RC with `0x80` → 0x800.
- **Timer interrupt:** MIE=1, MTIE=1, `pc=0x40`; raise `timer_intr` → one cycle later `epc_taken`=1 and `epc`=mtvec. After the edge: `mepc`=0x40, `mcause`=`0x8000_0007`, MIE=0, MPIE=1.
- **Priority and write suppression:** both interrupt lines high → `mcause`=`0x8000_000B`. A CSR write issued in the trap cycle leaves the target register unchanged.
- **mret with pending interrupt:** `mret` with interrupt pending and MPIE=1 → `epc`=`mepc` that cycle, MIE=1 after the edge, trap taken the following cycle.
- **Counter wrap and write:** write `mcycle` = `FFFF_FFFF` and `mcycleh` = `FFFF_FFFF` → the counter wraps to 0 two edges later. Writing `mcycle` = 5 → reads 5 next cycle, then 6.
- **Unimplemented and read-only addresses:** write 0x344 or 0x7C0 → no state change and reads 0 at 0x7C0. Reset asserted mid-trap → every register returns to its reset value.
